// File: rtl/sc_fifo_stream_out.sv
// ---------------------------------------------------------------------------
// sc_fifo_stream_out
// Downstream read adapter for the single-clock FIFO. It turns the FIFO's
// rd/data_out port (data registered one cycle after an accepted rd) into a
// valid/ready stream master with packet framing.
//
// Ports
//   clk         single clock, all logic on posedge
//   reset_n     asynchronous active-low reset
//   fifo_rd     read strobe to the FIFO
//   fifo_data   FIFO data_out, valid the cycle after an accepted rd
//   fifo_empty  FIFO empty flag
//   m_valid     stream word valid
//   m_data      stream word (queue head)
//   m_last      last beat of the current packet
//   m_ready     downstream accept
//   clear       synchronous flush, active high, driven with the FIFO clear
// ---------------------------------------------------------------------------
module sc_fifo_stream_out #(
    parameter int data_width = 256,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  fifo_rd,
    input  logic [data_width-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [data_width-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    input  logic                  clear
);

    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [data_width-1:0] q_mem [3];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [1:0]            occ;
    logic                  pend;
    logic [BEAT_W-1:0]     beat;
    logic                  push;
    logic                  pop;
    logic [2:0]            committed;

    // Three-entry ring buffer pointers wrap 0,1,2,0...
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is issued only when the queue can still absorb every word that
    // is already stored or in flight, so the decision never needs m_ready.
    // Gating with reset_n keeps the strobe low while reset is held.
    always_comb begin
        committed = {1'b0, occ} + {2'b00, pend};
        fifo_rd   = reset_n && !fifo_empty && !clear && (committed <= 3'd2);
        push      = pend && !clear;
        pop       = m_valid && m_ready && !clear;
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = q_mem[head];
    assign m_last  = m_valid && (beat == LAST_BEAT);

    // Control state: pointers, occupancy, in-flight flag and beat counter.
    // Clear wins over everything and also drops a word returning this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= 2'd0;
            tail <= 2'd0;
            occ  <= 2'd0;
            pend <= 1'b0;
            beat <= '0;
        end else if (clear) begin
            head <= 2'd0;
            tail <= 2'd0;
            occ  <= 2'd0;
            pend <= 1'b0;
            beat <= '0;
        end else begin
            pend <= fifo_rd && !fifo_empty;
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
                beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

    // Word storage; the returning FIFO word lands at the tail.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                q_mem[i] <= '0;
            end
        end else if (push) begin
            q_mem[tail] <= fifo_data;
        end
    end

    // The issue rule keeps occ + pend <= 3, so a push into a full queue
    // would mean the read gating is broken.
    assert property (@(posedge clk) disable iff (!reset_n) push |-> (occ != 2'd3));

endmodule

// File: tb/tb_sc_fifo_stream_out.sv
// ---------------------------------------------------------------------------
// tb_sc_fifo_stream_out
// Self-checking bench for sc_fifo_stream_out. The FIFO is emulated with a
// queue; the adapter is modelled as "words returned but not yet taken" plus
// one in-flight word, and the expected stream is simply the FIFO order.
// ---------------------------------------------------------------------------
module tb_sc_fifo_stream_out;

    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          clear = 1'b0;

    always #5 clk = ~clk;

    sc_fifo_stream_out #(
        .data_width (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .clear      (clear)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] mq[$];
    logic          pend_m = 1'b0;
    logic [DW-1:0] pend_word = '0;
    logic [DW-1:0] next_fifo_data = '0;
    int            beats = 0;
    int            cyc = 0;
    int            rd_count = 0;
    int            first_valid = -1;
    logic [DW-1:0] out_hist[$];
    logic          last_hist[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at the negedge, compare outputs against
    // the model, advance the model and the emulated FIFO, step to the next negedge.
    task automatic apply_stimulus(input logic rdy, input logic clr);
        logic exp_rd;
        logic hs;
        m_ready    = rdy;
        clear      = clr;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = next_fifo_data;
        #1;
        check_output("m_valid", m_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check_output("m_data", m_data, mq[0]);
            check_output("m_last", m_last, (beats % BL) == BL - 1);
        end
        exp_rd = !fifo_empty && !clr && ((mq.size() + int'(pend_m)) <= 2);
        check_output("fifo_rd", fifo_rd, exp_rd);
        if (prev_stall) begin
            check_output("stall_valid", m_valid, 1'b1);
            check_output("stall_data", m_data, prev_data);
            check_output("stall_last", m_last, prev_last);
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (fifo_rd) rd_count++;
        hs         = m_valid && rdy && !clr;
        prev_stall = m_valid && !rdy && !clr;
        prev_data  = m_data;
        prev_last  = m_last;
        if (hs) begin
            out_hist.push_back(m_data);
            last_hist.push_back(m_last);
        end
        if (clr) begin
            mq.delete();
            fifo_q.delete();
            pend_m = 1'b0;
            beats  = 0;
        end else begin
            if (hs) begin
                void'(mq.pop_front());
                beats++;
            end
            if (pend_m) mq.push_back(pend_word);
            pend_m = fifo_rd && !fifo_empty;
            if (pend_m) pend_word = fifo_q.pop_front();
        end
        next_fifo_data = pend_m ? pend_word : DW'($urandom);
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop at once.
    task automatic do_reset();
        @(negedge clk);
        fifo_empty = (fifo_q.size() == 0);
        m_ready    = 1'b0;
        clear      = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_output("rst_m_valid", m_valid, 1'b0);
        check_output("rst_fifo_rd", fifo_rd, 1'b0);
        check_output("rst_m_last", m_last, 1'b0);
        check_output("rst_m_data", m_data, '0);
        fifo_q.delete();
        mq.delete();
        out_hist.delete();
        last_hist.delete();
        pend_m         = 1'b0;
        beats          = 0;
        cyc            = 0;
        rd_count       = 0;
        first_valid    = -1;
        prev_stall     = 1'b0;
        next_fifo_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] written[$];
        int            base;
        int            budget;
        logic          found;

        #1 reset_n = 1'b0;

        // Test 1: preload 0..7, ready high, latency and back-to-back beats
        do_reset();
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(i));
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0);
        check_output("t1_first_valid", first_valid, 2);
        check_output("t1_beats", out_hist.size(), 8);
        for (int i = 0; i < out_hist.size(); i++) check_output("t1_word", out_hist[i], DW'(i));

        // Test 2: 12 words, m_last on beats 3, 7, 11 only
        do_reset();
        for (int i = 0; i < 12; i++) fifo_q.push_back(DW'(32'h100 + i));
        for (int i = 0; i < 14; i++) apply_stimulus(1'b1, 1'b0);
        check_output("t2_beats", out_hist.size(), 12);
        for (int i = 0; i < last_hist.size(); i++)
            check_output("t2_last", last_hist[i], (i == 3) || (i == 7) || (i == 11));

        // Test 3: backpressure, three reads then stall on word 0
        do_reset();
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(i));
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 1'b0);
        check_output("t3_reads", rd_count, 3);
        check_output("t3_valid", m_valid, 1'b1);
        check_output("t3_head", m_data, '0);
        for (int i = 0; i < 20 && out_hist.size() < 10; i++) apply_stimulus(1'b1, 1'b0);
        check_output("t3_beats", out_hist.size(), 10);
        for (int i = 0; i < out_hist.size(); i++) check_output("t3_word", out_hist[i], DW'(i));

        // Test 4: random ready and random FIFO writes, 1000 words
        do_reset();
        budget = 0;
        while (out_hist.size() < 1000 && budget < 10000) begin
            if (written.size() < 1000 && $urandom_range(0, 99) < 60) begin
                written.push_back(DW'($urandom));
                fifo_q.push_back(written[$]);
            end
            apply_stimulus($urandom_range(0, 1) == 1, 1'b0);
            budget++;
        end
        check_output("t4_beats", out_hist.size(), 1000);
        for (int i = 0; i < out_hist.size(); i++) begin
            check_output("t4_order", out_hist[i], written[i]);
            check_output("t4_last", last_hist[i], (i % BL) == BL - 1);
        end

        // Test 5: clear with two stored words and one in flight, mid-packet
        do_reset();
        for (int i = 0; i < 20; i++) fifo_q.push_back(DW'(32'h200 + i));
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (mq.size() == 2 && pend_m) found = 1'b1;
            else apply_stimulus(1'b0, 1'b0);
        end
        check_output("t5_reached", found, 1'b1);
        check_output("t5_midpacket", out_hist.size(), 2);
        apply_stimulus(1'b0, 1'b1);
        check_output("t5_cleared", m_valid, 1'b0);
        base = out_hist.size();
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h500 + i));
        for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b0);
        check_output("t5_beats", out_hist.size() - base, 8);
        if (out_hist.size() >= base + 4) begin
            check_output("t5_first", out_hist[base], 32'h500);
            check_output("t5_last0", last_hist[base], 1'b0);
            check_output("t5_last3", last_hist[base+3], 1'b1);
        end

        // Test 6: reset mid-stream while stalled, then resume
        do_reset();
        for (int i = 0; i < 12; i++) fifo_q.push_back(DW'(32'h700 + i));
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(32'h900 + i));
        for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b0);
        check_output("t6_beats", out_hist.size(), 6);
        if (out_hist.size() >= 4) begin
            check_output("t6_first", out_hist[0], 32'h900);
            check_output("t6_last3", last_hist[3], 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
